axis_sync_fifo: RTL and testbench
=================================

AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
- REQ-001 Parameter DATA_W, default 8: width of tdata on both ports.
- REQ-002 Parameter DEPTH, default 8: storage entries; SHALL be a power of two, minimum 2.
- REQ-003 clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 reset  input  1  asynchronous, active-high reset.
- REQ-005 s_tdata  input  DATA_W  upstream stream data.
- REQ-006 s_tvalid  input  1  upstream data valid.
- REQ-007 s_tlast  input  1  upstream end-of-packet marker.
- REQ-008 s_tready  output  1  FIFO can accept a beat.
- REQ-009 m_tdata  output  DATA_W  downstream stream data.
- REQ-010 m_tvalid  output  1  downstream data valid.
- REQ-011 m_tlast  output  1  downstream end-of-packet marker.
- REQ-012 m_tready  input  1  downstream consumer ready.
- REQ-013 level  output  log2(DEPTH)+1  number of beats currently stored.
- REQ-014 pkt_cnt  output  log2(DEPTH)+1  number of stored beats with tlast=1, i.e. complete packets held.

Function
- REQ-015 Push occurs on a rising edge where s_tvalid=1 and s_tready=1; pop occurs on a rising edge where m_tvalid=1 and m_tready=1.
- REQ-016 Each stored entry holds {tlast, tdata}; data and tlast SHALL emerge in push order, unmodified.
- REQ-017 First-word-fall-through: m_tdata/m_tlast SHALL present the oldest entry whenever m_tvalid=1, with no read-request cycle.
- REQ-018 Latency: a beat pushed at edge N SHALL be visible on m_* with m_tvalid=1 after edge N when the FIFO was empty (one-cycle latency).
- REQ-019 m_tvalid SHALL equal (level != 0); m_tdata/m_tlast are don't-care while m_tvalid=0.
- REQ-020 s_tready SHALL be a registered output equal to (next level < DEPTH); there SHALL be no combinational path from m_tready or s_tvalid to s_tready.
- REQ-021 When full (level=DEPTH), s_tready=0; a pop at that edge frees a slot and s_tready SHALL rise after that edge, not during it.
- REQ-022 Simultaneous push and pop with 0<level<DEPTH: level unchanged; both pointers advance.
- REQ-023 When empty, m_tvalid=0 so no pop can occur; a push takes effect normally.
- REQ-024 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; level SHALL stay within 0..DEPTH.
- REQ-025 pkt_cnt SHALL increment on push with s_tlast=1, decrement on pop with m_tlast=1, and stay unchanged when both occur at the same edge.
- REQ-026 Once m_tvalid=1, m_tdata/m_tlast SHALL remain stable until popped (AXI4-Stream rule); the FIFO SHALL never withdraw m_tvalid without a pop.
- REQ-027 Upstream protocol violations (s_tvalid dropped before acceptance) SHALL not corrupt stored data.

Reset
- REQ-028 While reset=1: pointers=0, level=0, pkt_cnt=0, m_tvalid=0, s_tready=0, asynchronously and independent of clk.
- REQ-029 s_tready SHALL rise on the first rising edge after reset deasserts.
- REQ-030 Reset asserted mid-transfer SHALL discard all stored beats; m_tvalid falls immediately; storage contents need not be cleared.

Verification
- REQ-031 Reset release, m_tready=1, push 0x11 (tlast=0) -> s_tready=1 one edge after release; m_tdata=0x11, m_tvalid=1 one edge after push; level 1 then 0 after pop.
- REQ-032 m_tready=0, push 0x01..0x08 with tlast on 0x04 and 0x08 -> level=8, pkt_cnt=2, s_tready=0; 9th beat 0x09 held upstream and not stored.
- REQ-033 From full, m_tready=1 for one edge with s_tvalid=1 -> 0x01 popped, s_tready=1 on the next cycle, 0x09 accepted afterwards; final drain order 0x02..0x09.
- REQ-034 Continuous push and pop with s_tvalid=m_tready=1 for 20 beats (0x00..0x13) -> full throughput after the first beat, output sequence identical, pointers wrap twice, level never exceeds 2.
- REQ-035 Push 5 beats, assert reset for half a cycle between edges -> m_tvalid=0, level=0, pkt_cnt=0 immediately; post-release output shows none of the 5 beats.
- REQ-036 Random s_tvalid/m_tready (≥10k cycles, scoreboard) -> no loss, duplication or reordering; m_* stable while m_tvalid=1 and m_tready=0.

Source files
------------

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock first-word-fall-through AXI4-Stream FIFO with level and packet count.
module axis_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d, pkt_q, pkt_d;
    logic            s_tready_q, s_tready_d;
    logic            push, pop;

    assign m_tvalid            = level_q != '0;
    assign {m_tlast, m_tdata}  = mem_q[rd_ptr_q];
    assign s_tready            = s_tready_q;
    assign level               = level_q;
    assign pkt_cnt             = pkt_q;

    always_comb begin
        push       = s_tvalid && s_tready_q;
        pop        = m_tvalid && m_tready;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        pkt_d      = pkt_q + LW'(push && s_tlast) - LW'(pop && m_tlast);
        // ready is a flop of the next level, so m_tready never reaches s_tready combinationally
        s_tready_d = level_d != LW'(DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pkt_q      <= '0;
            s_tready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pkt_q      <= pkt_d;
            s_tready_q <= s_tready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
    end
endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb_axis_sync_fifo: directed and scoreboarded checks of the FWFT stream FIFO.
module tb_axis_sync_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready = 1'b0;
    logic [3:0] level;
    logic [3:0] pkt_cnt;
    int checks = 0;
    int failures = 0;

    axis_sync_fifo #(.DATA_W(8), .DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .level(level), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_mvalid got %b exp 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_sready got %b exp 0", s_tready); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (pkt_cnt !== 4'd0) begin failures++; $display("FAIL rst_pkt got %0d exp 0", pkt_cnt); end
        reset = 1'b0;
        #1;
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rel_sready_early got %b exp 0", s_tready); end
        tick();
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL rel_sready got %b exp 1", s_tready); end
    endtask

    task automatic test_basic();
        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'h11; s_tlast = 1'b0;
        tick();
        s_tvalid = 1'b0;
        checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL basic_mvalid got %b exp 1", m_tvalid); end
        checks++; if (m_tdata !== 8'h11) begin failures++; $display("FAIL basic_data got %h exp 11", m_tdata); end
        checks++; if (level !== 4'd1) begin failures++; $display("FAIL basic_level got %0d exp 1", level); end
        tick();
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL basic_level_pop got %0d exp 0", level); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL basic_mvalid_pop got %b exp 0", m_tvalid); end
    endtask

    task automatic test_full();
        m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'(i); s_tlast = (i == 4 || i == 8);
            tick();
        end
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_level got %0d exp 8", level); end
        checks++; if (pkt_cnt !== 4'd2) begin failures++; $display("FAIL full_pkt got %0d exp 2", pkt_cnt); end
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL full_sready got %b exp 0", s_tready); end
        s_tdata = 8'h09; s_tlast = 1'b0;
        tick(); tick();
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_hold_level got %0d exp 8", level); end
        checks++; if (m_tdata !== 8'h01) begin failures++; $display("FAIL full_stable got %h exp 01", m_tdata); end
    endtask

    task automatic test_drain_from_full();
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        checks++; if (level !== 4'd7) begin failures++; $display("FAIL pop_level got %0d exp 7", level); end
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL pop_sready got %b exp 1", s_tready); end
        checks++; if (m_tdata !== 8'h02) begin failures++; $display("FAIL pop_head got %h exp 02", m_tdata); end
        tick();
        s_tvalid = 1'b0;
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL refill_level got %0d exp 8", level); end
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL refill_sready got %b exp 0", s_tready); end
        m_tready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 8'(i) || m_tlast !== (i == 4 || i == 8)) begin
                failures++; $display("FAIL drain_%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, m_tvalid, m_tdata, m_tlast, 8'(i), (i == 4 || i == 8));
            end
            tick();
        end
        checks++; if (level !== 4'd0 || pkt_cnt !== 4'd0 || m_tvalid !== 1'b0) begin failures++; $display("FAIL drain_end got lvl=%0d pkt=%0d v=%b exp 0 0 0", level, pkt_cnt, m_tvalid); end
    endtask

    task automatic test_back_to_back();
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'(i); s_tlast = (i % 5 == 4);
            tick();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 8'(i) || m_tlast !== (i % 5 == 4) || level !== 4'd1 || s_tready !== 1'b1) begin
                failures++; $display("FAIL b2b_%0d got d=%h l=%b lvl=%0d rdy=%b exp d=%h l=%b lvl=1 rdy=1", i, m_tdata, m_tlast, level, s_tready, 8'(i), (i % 5 == 4));
            end
        end
        s_tvalid = 1'b0;
        tick();
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL b2b_end got %0d exp 0", level); end
    endtask

    task automatic test_mid_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'hA0 + 8'(i); s_tlast = (i == 2);
            tick();
        end
        s_tvalid = 1'b0;
        checks++; if (level !== 4'd5 || pkt_cnt !== 4'd1) begin failures++; $display("FAIL mr_pre got lvl=%0d pkt=%0d exp 5 1", level, pkt_cnt); end
        #2 reset = 1'b1;
        #1;
        checks++; if (m_tvalid !== 1'b0 || level !== 4'd0 || pkt_cnt !== 4'd0 || s_tready !== 1'b0) begin
            failures++; $display("FAIL mr_async got v=%b lvl=%0d pkt=%0d rdy=%b exp 0 0 0 0", m_tvalid, level, pkt_cnt, s_tready);
        end
        #1 reset = 1'b0;
        tick();
        checks++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin failures++; $display("FAIL mr_release got rdy=%b v=%b exp 1 0", s_tready, m_tvalid); end
        s_tvalid = 1'b1; s_tdata = 8'h55; s_tlast = 1'b0;
        tick();
        s_tvalid = 1'b0;
        checks++; if (m_tdata !== 8'h55 || level !== 4'd1) begin failures++; $display("FAIL mr_after got d=%h lvl=%0d exp 55 1", m_tdata, level); end
        m_tready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [8:0] q[$];
        logic [8:0] beat;
        bit push, pop;
        int npkt = 0;
        for (int c = 0; c < 10000; c++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            beat = 9'($urandom);
            {s_tlast, s_tdata} = beat;
            m_tready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (level !== 4'(q.size()) || pkt_cnt !== 4'(npkt) || m_tvalid !== (q.size() != 0) || s_tready !== (q.size() < 8)) begin
                failures++; $display("FAIL rnd_state_%0d got lvl=%0d pkt=%0d v=%b rdy=%b exp lvl=%0d pkt=%0d", c, level, pkt_cnt, m_tvalid, s_tready, q.size(), npkt);
            end
            if (q.size() != 0) begin
                checks++;
                if ({m_tlast, m_tdata} !== q[0]) begin failures++; $display("FAIL rnd_data_%0d got %h exp %h", c, {m_tlast, m_tdata}, q[0]); end
            end
            push = s_tvalid && (q.size() < 8);
            pop = m_tready && (q.size() != 0);
            if (pop) begin npkt -= int'(q[0][8]); void'(q.pop_front()); end
            if (push) begin q.push_back(beat); npkt += int'(beat[8]); end
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL rnd_drain got %0d exp 0", level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_drain_from_full();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
